secuencia_ctrl: RTL and testbench

//   Test controller that sequences the serial sequence detector (secuencia: clk, reset, w, z).

---
 rtl/secuencia_ctrl_pkg.sv | 16 +
 rtl/secuencia_ctrl_if.sv | 26 ++
 rtl/secuencia_ctrl_piso_shift.sv | 37 +++
 rtl/secuencia_ctrl.sv | 114 +++++++++++
 tb/tb_secuencia_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/secuencia_ctrl_pkg.sv
// Shared types for the sequence-detector test controller.
package secuencia_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/secuencia_ctrl_if.sv
// Trigger-side and detector-side signals of the sequence test controller.
interface secuencia_ctrl_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [N-1:0]     data;
    logic             lsb_first;
    logic             z;
    logic             w;
    logic             det_rst;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic             hit;

    modport master (
        output start, data, lsb_first, z,
        input  w, det_rst, busy, done, match_cnt, hit
    );

    modport slave (
        input  start, data, lsb_first, z,
        output w, det_rst, busy, done, match_cnt, hit
    );
endinterface

// File: rtl/secuencia_ctrl_piso_shift.sv
// Parallel-in serial-out shifter; bit order chosen at load, serial bit always from sr[0].
module piso_shift #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         lsb_first,
    input  logic [N-1:0] data,
    output logic         sout
);

    logic [N-1:0] sr;
    logic [N-1:0] rev;

    always_comb begin
        rev = '0;
        for (int i = 0; i < int'(N); i++) begin
            rev[i] = data[N-1-i];
        end
    end

    // Zeros shift in behind the word, so sout idles at 0 once the word is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= lsb_first ? data : rev;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign sout = sr[0];

endmodule

// File: rtl/secuencia_ctrl.sv
// Test controller: loads a word, clears the detector, shifts the word onto w, counts z hits.
module secuencia_ctrl
    import secuencia_ctrl_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DRAIN = 2,
    parameter int unsigned CNT_W = 4
) (
    input logic             clk,
    input logic             reset,
    secuencia_ctrl_if.slave bus
);

    localparam int unsigned CW         = $clog2(max_u(N, DRAIN) + 1);
    localparam int unsigned DRAIN_LAST = (DRAIN > 0) ? DRAIN - 1 : 0;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             hit_q, hit_d;
    logic             busy_q, busy_d;
    logic             det_rst_q, det_rst_d;
    logic             done_q, done_d;
    logic             load;
    logic             shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            match_cnt_q <= '0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            det_rst_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            det_rst_q   <= det_rst_d;
            done_q      <= done_d;
        end
    end

    // Next state, shared bit/drain counter, match counter and next-cycle flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        match_cnt_d = match_cnt_q;
        load        = 1'b0;
        shift       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                load        = 1'b1;
                cnt_d       = '0;
                match_cnt_d = '0;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = (DRAIN > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DRAIN_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_SHIFT || state_q == S_DRAIN) && bus.z && (match_cnt_q != '1)) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end

        hit_d     = (match_cnt_d != '0);
        busy_d    = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_DRAIN);
        det_rst_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE);
        done_d    = (state_d == S_DONE);
    end

    piso_shift #(.N(N)) u_piso (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load),
        .shift     (shift),
        .lsb_first (bus.lsb_first),
        .data      (bus.data),
        .sout      (bus.w)
    );

    assign bus.det_rst   = det_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.hit       = hit_q;

endmodule

// File: tb/tb_secuencia_ctrl.sv
// Directed bench for secuencia_ctrl: vector table plus reset, held-start and saturation sequences.
module tb_secuencia_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    secuencia_ctrl_if #(.N(8), .CNT_W(4)) bi ();
    secuencia_ctrl_if #(.N(8), .CNT_W(2)) bs ();

    secuencia_ctrl #(.N(8), .DRAIN(2), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi.slave)
    );

    secuencia_ctrl #(.N(8), .DRAIN(2), .CNT_W(2)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bs.slave)
    );

    typedef struct packed {
        logic       start;
        logic [7:0] data;
        logic       lsb;
        logic       z;
        logic       w;
        logic       det_rst;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
        logic       hit;
    } vec_t;

    vec_t vt [26];
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic w, input logic dr, input logic busy,
                           input logic done, input logic [3:0] cnt, input logic hit);
        chk({tag, "_w"},       32'(bi.w),         32'(w));
        chk({tag, "_det_rst"}, 32'(bi.det_rst),   32'(dr));
        chk({tag, "_busy"},    32'(bi.busy),      32'(busy));
        chk({tag, "_done"},    32'(bi.done),      32'(done));
        chk({tag, "_cnt"},     32'(bi.match_cnt), 32'(cnt));
        chk({tag, "_hit"},     32'(bi.hit),       32'(hit));
    endtask

    initial begin
        // start, data, lsb, z | w, det_rst, busy, done, cnt, hit (outputs after that edge)
        vt[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[1]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[2]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[3]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1};
        vt[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1};
        vt[5]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1};
        vt[6]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1};
        vt[7]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1};
        vt[8]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1};
        vt[9]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1};
        vt[10] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1};
        vt[11] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1};
        vt[12] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1};
        vt[13] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1};
        vt[14] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1};
        vt[15] = '{1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vt[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};

        reset        = 1'b0;
        bi.start     = 1'b0;
        bi.data      = 8'h00;
        bi.lsb_first = 1'b0;
        bi.z         = 1'b0;
        bs.start     = 1'b0;
        bs.data      = 8'h00;
        bs.lsb_first = 1'b1;
        bs.z         = 1'b0;

        // Reset state, then release with no start.
        step();
        step();
        chk_all("rst", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        step();
        step();
        step();
        chk_all("idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Two full runs from the vector table.
        for (int i = 0; i < 26; i++) begin
            bi.start     = vt[i].start;
            bi.data      = vt[i].data;
            bi.lsb_first = vt[i].lsb;
            bi.z         = vt[i].z;
            step();
            chk_all($sformatf("v%0d", i), vt[i].w, vt[i].det_rst, vt[i].busy,
                    vt[i].done, vt[i].cnt, vt[i].hit);
        end
        bi.start = 1'b0;
        bi.z     = 1'b0;
        step();

        // start held high: a new run begins in the first IDLE cycle after DONE.
        bi.start     = 1'b1;
        bi.data      = 8'h3C;
        bi.lsb_first = 1'b1;
        step();
        chk("hold_busy_load", 32'(bi.busy), 32'd1);
        n = 0;
        while (!bi.done && n < 30) begin
            step();
            n++;
        end
        chk("hold_done_latency", 32'(n), 32'd11);
        step();
        chk("hold_idle_busy", 32'(bi.busy), 32'd0);
        chk("hold_idle_done", 32'(bi.done), 32'd0);
        step();
        chk("hold_restart_busy", 32'(bi.busy), 32'd1);
        bi.start = 1'b0;
        n = 0;
        while (!bi.done && n < 30) begin
            step();
            n++;
        end
        chk("hold_second_done", 32'(n), 32'd11);
        step();

        // Saturating counter on the CNT_W=2 instance.
        bs.start = 1'b1;
        bs.z     = 1'b1;
        step();
        bs.start = 1'b0;
        n = 0;
        while (!bs.done && n < 30) begin
            step();
            n++;
        end
        chk("sat_done", 32'(bs.done), 32'd1);
        chk("sat_cnt", 32'(bs.match_cnt), 32'd3);
        chk("sat_hit", 32'(bs.hit), 32'd1);
        bs.z = 1'b0;
        step();
        bs.start = 1'b1;
        step();
        chk("sat_load_hold", 32'(bs.match_cnt), 32'd3);
        bs.start = 1'b0;
        step();
        chk("sat_cleared", 32'(bs.match_cnt), 32'd0);
        chk("sat_hit_cleared", 32'(bs.hit), 32'd0);
        n = 0;
        while (!bs.done && n < 30) begin
            step();
            n++;
        end
        chk("sat_second_done", 32'(bs.done), 32'd1);
        step();

        // Asynchronous reset while bit 4 is on w.
        bi.start     = 1'b1;
        bi.data      = 8'hFF;
        bi.lsb_first = 1'b1;
        bi.z         = 1'b1;
        step();
        bi.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_pre_w", 32'(bi.w), 32'd1);
        chk("midrst_pre_busy", 32'(bi.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step();
        reset = 1'b1;
        bi.z  = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bi.done || bi.busy) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
